// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for one shared multi-cycle adder.
// A single operation is in flight at a time; results carry a timeout flag.
module adder_arbiter #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic        cin0,
    input  logic [4:0]  ctrl0,
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        cin1,
    input  logic [4:0]  ctrl1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] res_sum,
    output logic        res_cout,
    output logic        res_err,
    output logic        busy,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    output logic [4:0]  add_ctrl,
    output logic        add_start,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    input  logic        add_out_en
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [5:0] TO_CNT = 6'(TIMEOUT);

    state_t     state, state_nx;
    logic [5:0] wait_cnt;
    logic       last;
    logic       id;
    logic       grant_vld;
    logic       grant_id;
    logic       timed_out;

    // Tie goes to whoever was not served last; otherwise the lone requester.
    always_comb begin
        grant_vld = req0 | req1;
        grant_id  = req1;
        if (req0 && req1)
            grant_id = ~last;
    end

    // The result strobe beats the timeout when both land in the same cycle.
    assign timed_out = !add_out_en && (wait_cnt == TO_CNT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_vld) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (add_out_en || timed_out) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            last     <= 1'b1;
            id       <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            add_ctrl <= '0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        id       <= grant_id;
                        add_a    <= grant_id ? a1    : a0;
                        add_b    <= grant_id ? b1    : b0;
                        add_cin  <= grant_id ? cin1  : cin0;
                        add_ctrl <= grant_id ? ctrl1 : ctrl0;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (add_out_en) begin
                        res_sum  <= add_sum;
                        res_cout <= add_cout;
                        res_err  <= 1'b0;
                    end else if (timed_out) begin
                        res_sum  <= '0;
                        res_cout <= 1'b0;
                        res_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 6'd1;
                    end
                end
                RESP: last <= id;
                default: ;
            endcase
        end
    end

    // All pulses decode registered state only, so no input reaches them.
    assign add_start = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign done0     = (state == RESP) && !id;
    assign done1     = (state == RESP) &&  id;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 63: the maximum number of WAIT cycles allowed before an operation is abandoned.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  clk        input   1   single clock; all state updates on its rising edge
  rst_n      input   1   asynchronous, active-low reset
  req0       input   1   requester 0 operation request, level
  a0, b0     input   32  requester 0 operands
  cin0       input   1   requester 0 carry-in
  ctrl0      input   5   requester 0 adder control word
  req1, a1, b1, cin1, ctrl1   input   1/32/32/1/5   requester 1, same meanings
  done0      output  1   one-cycle pulse: requester 0 result valid
  done1      output  1   one-cycle pulse: requester 1 result valid
  res_sum    output  32  result sum, valid while done0/done1 is high
  res_cout   output  1   result carry-out, valid with done
  res_err    output  1   timeout flag, valid with done
  busy       output  1   high whenever the state is not IDLE
  add_a, add_b   output  32  operands to the shared multi-cycle adder
  add_cin    output  1   carry-in to the adder
  add_ctrl   output  5   control word to the adder
  add_start  output  1   one-cycle pulse that launches an adder operation
  add_sum    input   32  adder sum
  add_cout   input   1   adder carry-out
  add_out_en input   1   adder result-valid strobe

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-004 In IDLE with any req high, the block SHALL latch the winner's a, b, cin, ctrl and id, then go to ISSUE.
REQ-005 With only one req high, that requester SHALL win.
REQ-006 With both req high, the requester not served last SHALL win (round robin).
REQ-007 A 1-bit last-served pointer SHALL update in RESP.
REQ-008 In ISSUE, add_start SHALL be 1 for exactly one cycle; the block SHALL clear the wait counter and go to WAIT.
REQ-009 add_a, add_b, add_cin and add_ctrl SHALL be driven from the latched registers and held stable from ISSUE through RESP.
REQ-010 add_out_en SHALL be ignored outside WAIT.
REQ-011 In WAIT with add_out_en=1, the block SHALL capture add_sum and add_cout into res_sum and res_cout, set res_err=0, and go to RESP.
REQ-012 In WAIT with add_out_en=0, the 6-bit wait counter SHALL increment.
REQ-013 If the wait counter equals TIMEOUT and add_out_en=0, the block SHALL set res_sum=0, res_cout=0 and res_err=1, then go to RESP.
REQ-014 If add_out_en=1 in the same cycle the counter reaches TIMEOUT, the result SHALL win and no timeout SHALL be flagged.
REQ-015 In RESP, the block SHALL pulse done<id> for exactly one cycle, update the last-served pointer and return to IDLE.
REQ-016 done0 and done1 SHALL never be high in the same cycle.
REQ-017 res_sum, res_cout and res_err SHALL hold their values until the next capture.
REQ-018 Latency: with req sampled in IDLE at cycle 0, add_start SHALL be 1 in cycle 1, WAIT SHALL begin in cycle 2, and done SHALL assert in the cycle after add_out_en.
REQ-019 A requester SHALL hold req high and its operands stable until its done pulse.
REQ-020 Deasserting req mid-operation SHALL NOT abort the operation; done still pulses.
REQ-021 The block SHALL NOT accept a new request until it returns to IDLE.
REQ-022 A req still high in the cycle after done SHALL start a new operation.
REQ-023 No combinational path SHALL exist from any input to done0, done1 or add_start.
REQ-024 Arithmetic SHALL be performed only by the adder; the block passes operands unmodified and performs no width conversion.

Reset
REQ-025 While rst_n=0, asynchronously: state=IDLE, wait counter=0, last-served pointer=1 (requester 0 wins the first tie).
REQ-026 While rst_n=0, asynchronously, all outputs SHALL be 0: done0, done1, add_start, busy, res_err, res_sum, res_cout, add_a, add_b, add_cin and add_ctrl.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-028 After rst_n rises, the block SHALL accept requests from the first clock edge.

Verification
REQ-029 Single requester: req0, a0=16, b0=3, cin0=0; adder model returns out_en after 34 cycles -> add_start in cycle 1, done0 in cycle 36, res_sum=19, res_cout=0, res_err=0, done1 never asserted.
REQ-030 Signed operand: req1, a1=6, b1=0xFFFFFFFD (-3) -> done1, res_sum=3, res_cout=1, res_err=0.
REQ-031 Tie after reset: req0 and req1 held high -> order of served requesters is 0, 1, 0, 1; each done matches its own operands; no overlapping done pulses.
REQ-032 Timeout: adder model never asserts out_en -> done pulses 1 cycle after the counter reaches 63, with res_err=1 and res_sum=0; the next request then completes normally.
REQ-033 Stale strobe: out_en forced high during ISSUE only -> ignored; done follows the genuine out_en.
REQ-034 Reset mid-WAIT: rst_n pulled low -> all outputs go to 0 immediately and no done pulse occurs; a new req0 then completes with the correct sum.
